// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch responder.
// Provides default address/data widths, counter widths and the
// sequence-checker state encoding.
package fetch_pkg;

    localparam int unsigned AW_DEF      = 6;
    localparam int unsigned DW_DEF      = 32;
    localparam int unsigned FETCH_CNT_W = 16;
    localparam int unsigned WRAP_CNT_W  = 8;

    // The first-fetch check is not a state of its own.
    // It is evaluated on the CHK_IDLE -> CHK_RUN transition.
    typedef enum logic {
        CHK_IDLE = 1'b0,
        CHK_RUN  = 1'b1
    } chk_state_e;

endpackage

// File: rtl/fetch_seq_chk.sv
// Fetch address sequence checker.
// Flags any fetch address that does not follow the previous one by +1 (mod 2^AW).
// The first fetch after idle must be address 0.
// Also counts fetches from the top address, saturating.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   ce_i         - fetch enable
//   pc_i         - fetch address
//   seq_err_o    - sticky sequence-error flag
//   wrap_cnt_o   - saturating count of fetches from address 2^AW-1
module fetch_seq_chk
    import fetch_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce_i,
    input  logic [AW-1:0]         pc_i,
    output logic                  seq_err_o,
    output logic [WRAP_CNT_W-1:0] wrap_cnt_o
);

    chk_state_e            state_q, state_d;
    logic [AW-1:0]         prev_q, prev_d;
    logic                  seq_err_q, seq_err_d;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic [AW-1:0]         prev_inc;

    // Wraps naturally in AW bits, so the top address followed by 0 is legal.
    assign prev_inc = prev_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        seq_err_d  = seq_err_q;
        wrap_cnt_d = wrap_cnt_q;

        unique case (state_q)
            CHK_IDLE: begin
                if (ce_i) begin
                    if (pc_i != '0) begin
                        seq_err_d = 1'b1;
                    end
                    prev_d  = pc_i;
                    state_d = CHK_RUN;
                end
            end
            CHK_RUN: begin
                if (ce_i) begin
                    if (pc_i != prev_inc) begin
                        seq_err_d = 1'b1;
                    end
                    prev_d = pc_i;
                end else begin
                    state_d = CHK_IDLE;
                end
            end
            default: state_d = CHK_IDLE;
        endcase

        if (ce_i && (pc_i == '1) && (wrap_cnt_q != '1)) begin
            wrap_cnt_d = wrap_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CHK_IDLE;
            prev_q     <= '0;
            seq_err_q  <= 1'b0;
            wrap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            seq_err_q  <= seq_err_d;
            wrap_cnt_q <= wrap_cnt_d;
        end
    end

    assign seq_err_o  = seq_err_q;
    assign wrap_cnt_o = wrap_cnt_q;

endmodule

// File: rtl/inst_fetch_rsp.sv
// Instruction-fetch responder.
// Returns store[pc] one cycle after a ce=1 cycle.
// The instruction store can be loaded while fetch is idle.
// Also carries a sequence checker and fetch/wrap statistics.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   ce_i, pc_i     - fetch enable and address from the PC block
//   we_i, waddr_i, wdata_i - load port; writes are only accepted when ce_i=0
//   inst_o         - registered fetched word, holds while idle
//   inst_valid_o   - inst_o was fetched in the previous cycle
//   wr_rej_o       - one-cycle pulse per write rejected because of ce_i=1
//   seq_err_o      - sticky non-sequential-address flag
//   wrap_cnt_o     - saturating count of fetches from the top address
//   fetch_cnt_o    - total fetches, wraps modulo 2^16
module inst_fetch_rsp
    import fetch_pkg::*;
#(
    parameter int unsigned AW = AW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce_i,
    input  logic [AW-1:0]          pc_i,
    input  logic                   we_i,
    input  logic [AW-1:0]          waddr_i,
    input  logic [DW-1:0]          wdata_i,
    output logic [DW-1:0]          inst_o,
    output logic                   inst_valid_o,
    output logic                   wr_rej_o,
    output logic                   seq_err_o,
    output logic [WRAP_CNT_W-1:0]  wrap_cnt_o,
    output logic [FETCH_CNT_W-1:0] fetch_cnt_o
);

    logic [DW-1:0]          mem_q [2**AW];
    logic [DW-1:0]          inst_q;
    logic                   inst_valid_q;
    logic                   wr_rej_q;
    logic [FETCH_CNT_W-1:0] fetch_cnt_q;

    // The store is not reset.
    // A write during reset is still suppressed, so reset overrides the load port.
    always_ff @(posedge clk) begin
        if (!rst && we_i && !ce_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            wr_rej_q     <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            inst_valid_q <= ce_i;
            wr_rej_q     <= we_i && ce_i;
            if (ce_i) begin
                inst_q      <= mem_q[pc_i];
                fetch_cnt_q <= fetch_cnt_q + 1'b1;
            end
        end
    end

    fetch_seq_chk #(
        .AW(AW)
    ) u_seq_chk (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .pc_i       (pc_i),
        .seq_err_o  (seq_err_o),
        .wrap_cnt_o (wrap_cnt_o)
    );

    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;
    assign wr_rej_o     = wr_rej_q;
    assign fetch_cnt_o  = fetch_cnt_q;

endmodule

// File: tb/tb_inst_fetch_rsp.sv
// Self-checking bench for inst_fetch_rsp.
// Fetched words are checked through a scoreboard queue.
// Short control sequences are driven from a vector table.
module tb_inst_fetch_rsp;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [5:0]  pc;
    logic        we;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        wr_rej;
    logic        seq_err;
    logic [7:0]  wrap_cnt;
    logic [15:0] fetch_cnt;

    logic [31:0] model_mem [64];
    logic [31:0] sb_q [$];
    bit          sb_en;
    int          n_checks;
    int          n_pass;

    always #5 clk = ~clk;

    inst_fetch_rsp dut (
        .clk          (clk),
        .rst          (rst),
        .ce_i         (ce),
        .pc_i         (pc),
        .we_i         (we),
        .waddr_i      (waddr),
        .wdata_i      (wdata),
        .inst_o       (inst),
        .inst_valid_o (inst_valid),
        .wr_rej_o     (wr_rej),
        .seq_err_o    (seq_err),
        .wrap_cnt_o   (wrap_cnt),
        .fetch_cnt_o  (fetch_cnt)
    );

    typedef struct {
        logic        ce;
        logic [5:0]  pc;
        logic        we;
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic        exp_valid;
        logic        exp_rej;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle with the currently driven inputs.
    // Outputs are sampled 1ns after the edge.
    task automatic step();
        logic fetch;
        logic [31:0] exp_word;
        fetch = ce && !rst;
        if (fetch && sb_en) sb_q.push_back(model_mem[pc]);
        if (we && !ce && !rst) model_mem[waddr] = wdata;
        @(posedge clk);
        #1;
        if (sb_en) begin
            check("inst_valid", {31'b0, inst_valid}, {31'b0, fetch});
            if (fetch) begin
                if (sb_q.size() == 0) begin
                    check("sb_empty", 32'd1, 32'd0);
                end else begin
                    exp_word = sb_q.pop_front();
                    check("inst", inst, exp_word);
                end
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b0; we = 1'b0; pc = '0;
        step();
        rst = 1'b0;
        sb_q.delete();
    endtask

    task automatic fetch_run(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            ce = 1'b1; we = 1'b0; pc = 6'((first + i) % 64);
            step();
        end
    endtask

    task automatic idle();
        ce = 1'b0; we = 1'b0;
        step();
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sb_en    = 1'b1;
        rst = 1'b0; ce = 1'b0; pc = '0; we = 1'b0; waddr = '0; wdata = '0;

        vecs[0] = '{1'b1, 6'd0, 1'b0, 6'd0, 32'h0,      1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 6'd1, 1'b1, 6'd3, 32'hDEAD,   1'b1, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 6'd2, 1'b0, 6'd0, 32'h0,      1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 6'd5, 1'b0, 6'd0, 32'h0,      1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'h0,      1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 6'd0, 1'b0, 6'd0, 32'h0,      1'b0, 1'b0, 1'b1};

        // Reset state.
        do_reset();
        check("rst_inst", inst, 32'h0);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_wr_rej", {31'b0, wr_rej}, 32'h0);
        check("rst_seq_err", {31'b0, seq_err}, 32'h0);
        check("rst_wrap_cnt", {24'b0, wrap_cnt}, 32'h0);
        check("rst_fetch_cnt", {16'b0, fetch_cnt}, 32'h0);

        // Load the store while fetch is idle.
        for (int i = 0; i < 64; i++) begin
            ce = 1'b0; we = 1'b1; waddr = 6'(i); wdata = 32'hA000_0000 + 32'(i);
            step();
            check("load_no_rej", {31'b0, wr_rej}, 32'h0);
        end
        we = 1'b0;

        // Three sequential laps, crossing 63 -> 0 twice.
        fetch_run(0, 64);
        check("lap1_fetch_cnt", {16'b0, fetch_cnt}, 32'd64);
        check("lap1_wrap_cnt", {24'b0, wrap_cnt}, 32'd1);
        check("lap1_seq_err", {31'b0, seq_err}, 32'h0);
        fetch_run(0, 128);
        check("lap3_wrap_cnt", {24'b0, wrap_cnt}, 32'd3);
        check("lap3_seq_err", {31'b0, seq_err}, 32'h0);
        idle();
        check("lap3_fetch_cnt", {16'b0, fetch_cnt}, 32'd192);

        // Sequence error 0,1,2,5 with a rejected write folded in.
        do_reset();
        foreach (vecs[i]) begin
            ce = vecs[i].ce; pc = vecs[i].pc; we = vecs[i].we;
            waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            step();
            check($sformatf("vec%0d_valid", i), {31'b0, inst_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_rej", i), {31'b0, wr_rej}, {31'b0, vecs[i].exp_rej});
            check($sformatf("vec%0d_err", i), {31'b0, seq_err}, {31'b0, vecs[i].exp_err});
        end

        // The rejected write must not have reached address 3.
        do_reset();
        fetch_run(0, 4);
        check("rej_addr3", inst, 32'hA000_0003);
        idle();

        // A single rejected write pulses wr_rej for exactly one cycle.
        ce = 1'b1; pc = 6'd4; we = 1'b1; waddr = 6'd3; wdata = 32'hDEAD;
        step();
        we = 1'b0;
        check("rej_pulse_hi", {31'b0, wr_rej}, 32'h1);
        ce = 1'b1; pc = 6'd5;
        step();
        check("rej_pulse_lo", {31'b0, wr_rej}, 32'h0);
        idle();

        // A first fetch from a nonzero address sets seq_err.
        do_reset();
        ce = 1'b1; pc = 6'd7;
        step();
        check("first_pc7_err", {31'b0, seq_err}, 32'h1);
        idle();

        // Reset mid-stream at pc=20.
        do_reset();
        fetch_run(0, 20);
        rst = 1'b1; ce = 1'b1; pc = 6'd20;
        step();
        rst = 1'b0;
        sb_q.delete();
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_valid", {31'b0, inst_valid}, 32'h0);
        check("mid_rst_err", {31'b0, seq_err}, 32'h0);
        check("mid_rst_fetch_cnt", {16'b0, fetch_cnt}, 32'h0);
        check("mid_rst_wrap_cnt", {24'b0, wrap_cnt}, 32'h0);
        fetch_run(0, 10);
        check("restart_err", {31'b0, seq_err}, 32'h0);
        idle();

        // Long run: fetch_cnt wraps and wrap_cnt saturates.
        do_reset();
        sb_en = 1'b0;
        fetch_run(0, 70000);
        sb_en = 1'b1;
        idle();
        check("sat_fetch_cnt", {16'b0, fetch_cnt}, 32'd4464);
        check("sat_wrap_cnt", {24'b0, wrap_cnt}, 32'd255);
        check("sat_seq_err", {31'b0, seq_err}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
